// File: rtl/vpm_pkg.sv
// Shared constants for the VPM pipeline sink: error-flag bit positions and counter sizing.
// Combinational only; no latency or backpressure of its own.
package vpm_pkg;

  localparam int VPM_SINK_ERR_OVF = 0;
  localparam int VPM_SINK_ERR_UDF = 1;
  localparam int VPM_SINK_ERR_W   = 2;

  typedef logic [VPM_SINK_ERR_W-1:0] vpm_sink_err_t;

  // Counters must represent 0..depth inclusive, hence depth + 1.
  function automatic int vpm_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vpm_sink_fifo.sv
// First-word fall-through FIFO for the pipe sink: push in cycle N is visible in cycle N+1.
// Push into a full FIFO is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module vpm_sink_fifo
  import vpm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = vpm_cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/vpm_pipe_sink.sv
// Sink of a non-stallable VPM stage pipeline: buffers arriving words and presents them valid/ready.
// Push-to-visible 1 cycle; head stall is credit-based on occupancy plus words in flight, from registers only.
module vpm_pipe_sink
  import vpm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  head_valid,
  input  logic                  pipe_kill,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  hz_stall_n,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int CNT_W = vpm_cnt_w(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  vpm_sink_err_t    err_q, err_d;
  logic [CNT_W-1:0] occ;
  logic [CNT_W:0]   credit_sum;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             ovf_evt;
  logic             udf_evt;

  vpm_sink_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ),
    .rdata (out_data)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Every word already injected owns a FIFO slot, so the sum can never legally exceed depth.
  assign credit_sum = {1'b0, occ} + {1'b0, in_flight_q};
  assign hz_stall_n = rst_n && (credit_sum < DEPTH_C);

  always_comb begin
    in_flight_d = in_flight_q;
    udf_evt     = 1'b0;
    if (pipe_kill) begin
      in_flight_d = '0;
    end else begin
      case ({head_valid, in_valid})
        2'b10: begin
          if (in_flight_q != CNT_MAX) begin
            in_flight_d = in_flight_q + CNT_W'(1);
          end
        end
        2'b01: begin
          if (in_flight_q == '0) begin
            udf_evt = 1'b1;
          end else begin
            in_flight_d = in_flight_q - CNT_W'(1);
          end
        end
        default: in_flight_d = in_flight_q;
      endcase
    end
  end

  always_comb begin
    ovf_evt = (head_valid && !hz_stall_n) || (in_valid && fifo_full && !pop);
    err_d   = err_q;
    if (ovf_evt) begin
      err_d[VPM_SINK_ERR_OVF] = 1'b1;
    end
    if (udf_evt) begin
      err_d[VPM_SINK_ERR_UDF] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight_q <= '0;
      err_q       <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
    end
  end

  assign err_overflow  = err_q[VPM_SINK_ERR_OVF];
  assign err_underflow = err_q[VPM_SINK_ERR_UDF];

endmodule

// File: tb/tb_vpm_pipe_sink.sv
// Bench for vpm_pipe_sink: models a 4-stage pipeline in front of the sink and scoreboards popped data.
module tb_vpm_pipe_sink;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          head_valid = 1'b0;
  logic          pipe_kill = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          hz_stall_n;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          err_overflow;
  logic          err_underflow;

  int checks = 0;
  int errors = 0;
  bit obey = 1'b1;
  logic [DW-1:0] exp_q [$];
  bit            pv [4];
  logic [DW-1:0] pd [4];

  vpm_pipe_sink #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .head_valid    (head_valid),
    .pipe_kill     (pipe_kill),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .hz_stall_n    (hz_stall_n),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit pipe_busy();
    return pv[0] | pv[1] | pv[2] | pv[3];
  endfunction

  // One clock: drive head/kill, deliver stage-O word (or a forced one), advance the pipe model.
  task automatic step(input logic hv, input logic [DW-1:0] hd, input logic kill,
                      input logic fv, input logic [DW-1:0] fd);
    head_valid = hv;
    pipe_kill  = kill;
    in_valid   = pv[3] | fv;
    in_data    = fv ? fd : pd[3];
    if (in_valid) exp_q.push_back(in_data);
    @(posedge clk);
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = hv;
    pd[0] = hd;
    if (kill) for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    #1;
    head_valid = 1'b0;
    pipe_kill  = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic fill(input string tag, input int base);
    int n;
    n = 0;
    for (int i = 0; i < 16 && hz_stall_n; i++) begin
      step(1'b1, DW'(base + i), 1'b0, 1'b0, '0);
      n++;
    end
    chk({tag, "_accepted"}, n, 8);
    chk({tag, "_stall"}, hz_stall_n, 1'b0);
    repeat (4) idle();
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int c = 0; c < 60 && (exp_q.size() != 0 || pipe_busy()); c++) idle();
    out_ready = 1'b0;
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every handshake and watches the credit invariant.
  initial begin
    logic [DW-1:0] e;
    int sum;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_data: got %0h expected nothing (scoreboard empty)", out_data);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
              errors++;
              $display("FAIL pop_data: got %0h expected %0h", out_data, e);
            end
          end
        end
        if (obey) begin
          sum = int'(dut.u_fifo.count_q) + int'(dut.in_flight_q);
          checks++;
          if (sum > DEPTH) begin
            errors++;
            $display("FAIL credit_invariant: got %0d expected <= %0d", sum, DEPTH);
          end
        end
      end
    end
  end

  initial begin
    int gaps;
    int sent;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("stall_in_reset", hz_stall_n, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_stall_n", hz_stall_n, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err_ovf", err_overflow, 1'b0);
    chk("rst_err_udf", err_underflow, 1'b0);

    fill("fill", 'h10);
    chk("full_out_valid", out_valid, 1'b1);
    chk("full_head", out_data, 'h10);
    chk("full_stall", hz_stall_n, 1'b0);
    chk("full_err_ovf", err_overflow, 1'b0);
    chk("full_err_udf", err_underflow, 1'b0);

    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    chk("credit_release", hz_stall_n, 1'b1);

    out_ready = 1'b1;
    gaps = 0;
    sent = 0;
    for (int c = 0; c < 60 && sent < 20; c++) begin
      if (hz_stall_n) begin
        step(1'b1, DW'('h20 + sent), 1'b0, 1'b0, '0);
        sent++;
      end else begin
        gaps++;
        idle();
      end
    end
    chk("stream_gaps", gaps, 0);
    drain("stream");

    for (int i = 0; i < 4; i++) step(1'b1, DW'('h40 + i), 1'b0, 1'b0, '0);
    step(1'b1, 'h44, 1'b1, 1'b0, '0);
    chk("kill_err_udf", err_underflow, 1'b0);
    chk("kill_stall_n", hz_stall_n, 1'b1);
    chk("kill_kept_word", out_data, 'h40);
    step(1'b0, '0, 1'b0, 1'b1, 'h55);
    chk("surv_err_udf", err_underflow, 1'b1);
    chk("surv_err_ovf", err_overflow, 1'b0);
    drain("kill");

    fill("refill", 'h60);
    chk("refill_head", out_data, 'h60);
    out_ready = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1, 'h70);
    out_ready = 1'b0;
    chk("pushpop_full_stall", hz_stall_n, 1'b0);
    chk("pushpop_err_ovf", err_overflow, 1'b0);
    chk("pushpop_head", out_data, 'h61);

    obey = 1'b0;
    step(1'b1, 'h80, 1'b0, 1'b0, '0);
    chk("viol_err_ovf", err_overflow, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    obey = 1'b1;
    drain("viol");
    chk("ovf_sticky", err_overflow, 1'b1);
    chk("udf_sticky", err_underflow, 1'b1);

    for (int i = 0; i < 3; i++) step(1'b1, DW'('h90 + i), 1'b0, 1'b0, '0);
    repeat (4) idle();
    chk("pre_reset_out_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_stall_n", hz_stall_n, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_stall_n", hz_stall_n, 1'b1);
    chk("post_reset_out_valid", out_valid, 1'b0);
    chk("post_reset_err_ovf", err_overflow, 1'b0);
    chk("post_reset_err_udf", err_underflow, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
